// File: rtl/led_pkg.sv
// Shared types, register offsets and the byte-lane merge helper for the
// led_pwm_wb block. Optional blink support is controlled by LED_BLINK_EN.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_PWM   = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_e;

    localparam logic [11:0] LED_CTRL     = 12'h000;
    localparam logic [11:0] LED_PRESCALE = 12'h004;
    localparam logic [11:0] LED_BLINK_R  = 12'h008;
    localparam logic [11:0] LED_CH_BASE  = 12'h010;

    // Duty is stored at its widest legal size; unused upper bits stay 0.
    typedef struct packed {
        led_mode_e   mode;
        logic [7:0]  duty;
    } led_ch_t;

    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus, 32-bit data with byte address and byte selects.
// dat_i / dat_o are named from the slave's point of view.
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;

    modport slave  (input  cyc, stb, we, adr, sel, dat_i,
                    output dat_o, ack, stall);
    modport master (output cyc, stb, we, adr, sel, dat_i,
                    input  dat_o, ack, stall);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED output: selects off / on / PWM / blink and registers the result.
// Blink mode falls back to steady on when LED_BLINK_EN is not defined.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  led_mode_e        mode,
    input  logic [PWM_W-1:0] duty,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             phase,
    output logic             led
);

    logic led_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        led_next = 1'b0;
        if (en) begin
            case (mode)
                LED_OFF:   led_next = 1'b0;
                LED_ON:    led_next = 1'b1;
                LED_PWM:   led_next = (pwm_cnt < duty);
`ifdef LED_BLINK_EN
                LED_BLINK: led_next = phase;
`else
                LED_BLINK: led_next = 1'b1;
`endif
                default:   led_next = 1'b0;
            endcase
        end
    end

`ifndef LED_BLINK_EN
    logic unused_phase;
    assign unused_phase = phase;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) led <= 1'b0;
        else        led <= led_next;
    end

endmodule

// File: rtl/led_pwm_wb.sv
// Multi-channel LED controller: Wishbone registers, prescaler, shared PWM and
// blink counters. Blink counter, phase and BLINK register exist only with LED_BLINK_EN.
module led_pwm_wb
    import led_pkg::*;
#(
    parameter int size     = 'h1000,
    parameter int NUM_LEDS = 8,
    parameter int PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    wb_if.slave                 wb,
    output logic [NUM_LEDS-1:0] led
);

    localparam int         AW        = $clog2(size);
    localparam int         WW        = AW - 2;
    localparam logic [7:0] DUTY_MASK = 8'((1 << PWM_W) - 1);

    localparam logic [WW-1:0] W_CTRL     = WW'(LED_CTRL >> 2);
    localparam logic [WW-1:0] W_PRESCALE = WW'(LED_PRESCALE >> 2);
    localparam logic [WW-1:0] W_CH_BASE  = WW'(LED_CH_BASE >> 2);

    logic             ctrl_en;
    logic [15:0]      prescale;
    led_ch_t          ch [NUM_LEDS];
    logic [15:0]      pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic             phase;

    logic             req;
    logic             wr;
    logic [WW-1:0]    word;
    logic [WW-1:0]    ch_rel;
    logic             ch_hit;
    logic             prescale_wr;
    logic             tick;
    logic [31:0]      rdata;
    logic [31:0]      wr_data;

    assign req         = wb.cyc && wb.stb;
    assign wr          = req && wb.we;
    assign word        = wb.adr[AW-1:2];
    assign ch_rel      = word - W_CH_BASE;
    assign ch_hit      = (word >= W_CH_BASE) && (ch_rel < WW'(NUM_LEDS));
    assign prescale_wr = wr && (word == W_PRESCALE);
    // A PRESCALE write restarts the prescaler and swallows a coincident tick.
    assign tick        = ctrl_en && (pre_cnt == prescale) && !prescale_wr;
    assign wb.stall    = 1'b0;

`ifdef LED_BLINK_EN
    localparam logic [WW-1:0] W_BLINK = WW'(LED_BLINK_R >> 2);

    logic [15:0] blink;
    logic [15:0] blink_cnt;
    logic        blink_wr;

    assign blink_wr = wr && (word == W_BLINK);
`endif

    // Current register value at the addressed word; also the base for sel merging.
    always_comb begin
        rdata = '0;
        if (word == W_CTRL) begin
            rdata = {31'd0, ctrl_en};
        end else if (word == W_PRESCALE) begin
            rdata = {16'd0, prescale};
`ifdef LED_BLINK_EN
        end else if (word == W_BLINK) begin
            rdata = {16'd0, blink};
`endif
        end else if (ch_hit) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (ch_rel == WW'(i)) rdata = {14'd0, ch[i].mode, 8'd0, ch[i].duty};
            end
        end
        wr_data = apply_sel(rdata, wb.dat_i, wb.sel);
    end

    // NOTE: the channel register bank is small flops, not RAM, so it is fully reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb.ack   <= 1'b0;
            wb.dat_o <= '0;
            ctrl_en  <= 1'b0;
            prescale <= '0;
            for (int i = 0; i < NUM_LEDS; i++) ch[i] <= '0;
        end else begin
            wb.ack   <= req;
            wb.dat_o <= (req && !wb.we) ? rdata : '0;
            if (wr) begin
                if (word == W_CTRL)     ctrl_en  <= wr_data[0];
                if (word == W_PRESCALE) prescale <= wr_data[15:0];
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (ch_hit && (ch_rel == WW'(i))) begin
                        ch[i].duty <= wr_data[7:0] & DUTY_MASK;
                        ch[i].mode <= led_mode_e'(wr_data[17:16]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ctrl_en) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (prescale_wr || (pre_cnt == prescale)) pre_cnt <= '0;
            else                                      pre_cnt <= pre_cnt + 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

`ifdef LED_BLINK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)        blink <= '0;
        else if (blink_wr) blink <= wr_data[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ctrl_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_wr) begin
            blink_cnt <= '0;
        end else if (tick) begin
            if (blink_cnt == blink) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end
`else
    assign phase = 1'b0;
`endif

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_pwm_channel #(.PWM_W(PWM_W)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (ctrl_en),
            .mode    (ch[g].mode),
            .duty    (ch[g].duty[PWM_W-1:0]),
            .pwm_cnt (pwm_cnt),
            .phase   (phase),
            .led     (led[g])
        );
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, wb.adr[31:AW], wb.adr[1:0], wr_data[31:18]};

endmodule

// File: tb/tb_led_pwm_wb.sv
// Directed self-checking bench for led_pwm_wb; blink checks follow LED_BLINK_EN.
module tb_led_pwm_wb;

    localparam int NUM_LEDS = 8;
    localparam int PWM_W    = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_LEDS-1:0] led;

    wb_if wb_bus ();

    led_pwm_wb #(.size('h1000), .NUM_LEDS(NUM_LEDS), .PWM_W(PWM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          ack_seen = 1'b0;
    logic [31:0] rd;
    int          cnt;
    int          cnt2;
    int          mism;
    logic [255:0] pattern;
    logic        prev;

    always @(negedge clk) if (wb_bus.ack === 1'b1) ack_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = 1'b1;
        wb_bus.adr = a; wb_bus.dat_i = d; wb_bus.sel = s;
        @(negedge clk);
        check("wr_ack", {31'd0, wb_bus.ack}, 32'd1);
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = 1'b0;
        wb_bus.adr = a; wb_bus.sel = 4'hF;
        @(negedge clk);
        check("rd_ack", {31'd0, wb_bus.ack}, 32'd1);
        d = wb_bus.dat_o;
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0;
    endtask

    initial begin
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
        wb_bus.adr = '0; wb_bus.sel = '0; wb_bus.dat_i = '0;

        // Reset held for three clocks
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'h0);
        check("rst_ack", {31'd0, wb_bus.ack}, 32'd0);
        check("rst_dat", wb_bus.dat_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_ack", {31'd0, ack_seen}, 32'd0);
        wb_read(32'h000, rd); check("rst_ctrl", rd, 32'h0);
        wb_read(32'h004, rd); check("rst_prescale", rd, 32'h0);
        wb_read(32'h008, rd); check("rst_blink", rd, 32'h0);
        for (int i = 0; i < NUM_LEDS; i++) begin
            wb_read(32'h010 + 32'(4 * i), rd); check("rst_ch", rd, 32'h0);
        end

        // Byte-lane write and ack timing
        @(negedge clk);
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = 1'b1;
        wb_bus.adr = 32'h018; wb_bus.dat_i = 32'h0001_0080; wb_bus.sel = 4'b0101;
        #1 check("ack_not_early", {31'd0, wb_bus.ack}, 32'd0);
        @(negedge clk);
        check("ack_one_clock", {31'd0, wb_bus.ack}, 32'd1);
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
        @(negedge clk);
        check("ack_single", {31'd0, wb_bus.ack}, 32'd0);
        wb_read(32'h018, rd); check("ch2_rw", rd, 32'h0001_0080);
        wb_write(32'h01C, 32'hFFFF_FFFF, 4'b0001);
        wb_read(32'h01C, rd); check("ch3_lane0", rd, 32'h0000_00FF);
        wb_write(32'h01C, 32'h0002_1234, 4'b0100);
        wb_read(32'h01C, rd); check("ch3_lane2", rd, 32'h0002_00FF);
        wb_write(32'h004, 32'hFFFF_1234, 4'hF);
        wb_read(32'h004, rd); check("prescale_upper0", rd, 32'h0000_1234);
        wb_write(32'h000, 32'hFFFF_FFFF, 4'hF);
        wb_read(32'h000, rd); check("ctrl_upper0", rd, 32'h0000_0001);
        wb_write(32'h000, 32'h0, 4'hF);
        wb_write(32'h800, 32'hDEAD_BEEF, 4'hF);
        wb_read(32'h800, rd); check("unmapped_800", rd, 32'h0);
        wb_read(32'h00C, rd); check("reserved_00c", rd, 32'h0);
        wb_write(32'h018, 32'h0, 4'hF);
        wb_write(32'h01C, 32'h0, 4'hF);
        wb_write(32'h004, 32'h0, 4'hF);

        // PWM duty 64/256 with a tick every clock
        wb_write(32'h010, 32'h0002_0040, 4'hF);
        wb_write(32'h000, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); pattern[i] = led[0]; if (led[0]) cnt++;
        end
        check("pwm64_win1", 32'(cnt), 32'd64);
        cnt = 0; mism = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); if (led[0]) cnt++; if (led[0] !== pattern[i]) mism++;
        end
        check("pwm64_win2", 32'(cnt), 32'd64);
        check("pwm64_period", 32'(mism), 32'd0);
        wb_write(32'h010, 32'h0002_00FF, 4'hF);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin @(negedge clk); if (led[0]) cnt++; end
        check("pwm255", 32'(cnt), 32'd255);
        wb_write(32'h010, 32'h0002_0000, 4'hF);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin @(negedge clk); if (led[0]) cnt++; end
        check("pwm0", 32'(cnt), 32'd0);

        // Blink: tick every 10 clocks, half-period of 5 ticks
        wb_write(32'h004, 32'd9, 4'hF);
        wb_write(32'h008, 32'd4, 4'hF);
        wb_write(32'h014, 32'h0003_0000, 4'hF);
`ifdef LED_BLINK_EN
        wb_read(32'h008, rd); check("blink_reg", rd, 32'd4);
        prev = led[1]; cnt = 0;
        while (led[1] === prev && cnt < 200) begin @(negedge clk); cnt++; end
        check("blink_first_edge", {31'd0, cnt < 200}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            prev = led[1]; cnt2 = 0;
            do begin @(negedge clk); cnt2++; end while (led[1] === prev && cnt2 < 200);
            check("blink_half_period", 32'(cnt2), 32'd50);
        end
`else
        wb_read(32'h008, rd); check("blink_reg_absent", rd, 32'd0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (led[1] !== 1'b1) cnt++; end
        check("mode3_steady_on", 32'(cnt), 32'd0);
`endif

        // Global disable and PWM restart
        for (int i = 0; i < NUM_LEDS; i++) wb_write(32'h010 + 32'(4 * i), 32'h0001_0000, 4'hF);
        @(negedge clk);
        check("all_on", 32'(led), 32'hFF);
        wb_write(32'h000, 32'h0, 4'hF);
        check("disable_at_ack", 32'(led), 32'hFF);
        @(negedge clk);
        check("disable_next", 32'(led), 32'h0);
        for (int i = 1; i < NUM_LEDS; i++) wb_write(32'h010 + 32'(4 * i), 32'h0, 4'hF);
        wb_write(32'h010, 32'h0002_0040, 4'hF);
        wb_write(32'h004, 32'h0, 4'hF);
        wb_write(32'h000, 32'h1, 4'hF);
        check("reenable_at_ack", 32'(led), 32'h0);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin @(negedge clk); if (led[0]) cnt++; end
        check("restart_high_run", 32'(cnt), 32'd64);
        @(negedge clk);
        check("restart_low", {31'd0, led[0]}, 32'd0);

        // Reset in the middle of a read while PWM runs
        wb_write(32'h018, 32'h0001_0000, 4'hF);
        @(negedge clk);
        check("pre_rst_led2", {31'd0, led[2]}, 32'd1);
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = 1'b0; wb_bus.adr = 32'h010;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ack", {31'd0, wb_bus.ack}, 32'd0);
        check("midrst_led", 32'(led), 32'h0);
        check("midrst_dat", wb_bus.dat_o, 32'h0);
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0;
        @(negedge clk);
        check("midrst_ack_after", {31'd0, wb_bus.ack}, 32'd0);
        rst_n = 1'b1;
        wb_read(32'h000, rd); check("midrst_ctrl", rd, 32'h0);
        wb_read(32'h010, rd); check("midrst_ch0", rd, 32'h0);
        wb_read(32'h018, rd); check("midrst_ch2", rd, 32'h0);
        wb_read(32'h004, rd); check("midrst_prescale", rd, 32'h0);
        check("midrst_led_after", 32'(led), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_wb.md
# led_pwm_wb

Multi-channel LED controller on a Wishbone slave port: the successor of the single-register `led` peripheral, placed at `led_base_addr` behind `wb_interconnect_sharedbus`. Each of `NUM_LEDS` outputs is independently set off, on, PWM-dimmed, or blinking. A shared prescaler drives the timing. Software configures everything through word-aligned registers.

## Interface
- `size`, `'h1000`: decoded address window in bytes; accesses beyond the register map read 0 and ignore writes.
- `NUM_LEDS`, 8: channel count, 1..16.
- `PWM_W`, 8: PWM counter and duty width, 4..8.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `wb`  `wb_if.slave`  –  pipelined Wishbone slave (32-bit data, byte address, `sel`); `stall` is tied 0.
- `led`  out  `NUM_LEDS`  LED drive; active-high.

## Operation
- Register map, byte offsets; upper bits read 0:
  - 0x00 `CTRL`: bit0 `EN`, the global enable.
  - 0x04 `PRESCALE[15:0]`: one tick every `PRESCALE+1` clocks.
  - 0x08 `BLINK[15:0]`: blink half-period in ticks, minus 1.
  - 0x10+4·i `CH[i]`: `[PWM_W-1:0]` `DUTY`; `[17:16]` `MODE` (0 off, 1 on, 2 pwm, 3 blink).
- Writes honour `sel` per byte lane. Reads return the full register.
- Prescaler behaviour:
  - 16-bit counter counts 0..`PRESCALE`.
  - At `PRESCALE` it wraps to 0 and asserts `tick` for one clock.
  - Runs only while `EN`=1, and is cleared to 0 when `EN`=0.
- PWM counter:
  - `PWM_W` bits, increments on `tick`, wraps from all-ones to 0.
  - PWM channel output is `pwm_cnt < DUTY`.
  - `DUTY`=0 gives constant off. All-ones gives (2^`PWM_W`−1)/2^`PWM_W` duty.
- Blink logic:
  - 16-bit counter increments on `tick`.
  - At `BLINK` it wraps to 0 and toggles `phase`.
  - Blink channel output is `phase`.
- Channel output when `EN`=0: all `led` are 0, regardless of mode.
- Writing `PRESCALE` or `BLINK` clears the matching counter, so there is no long wait after lowering the value.
- `MODE` and `DUTY` changes take effect on the next clock, not on period boundaries.

## Timing
- Every `stb` with `cyc` gets `ack` exactly one clock later. There are no wait states, no back-to-back penalty and no `err`.
- A write's register update and its `ack` share the same clock edge.
- Read data is registered and valid with `ack`.
- `led` is registered and changes one clock after the state that causes it:
  - a tick,
  - a register write, or
  - a counter wrap.
- Reset (`rst_n`=0 at a `clk` edge), including mid-transaction:
  - all registers, counters and `phase` go to 0, and `led` goes to 0;
  - `ack` is 0 and `dat_o` is 0;
  - a pending `ack` is dropped.
- Simultaneous events:
  - A register write and a counter tick in the same clock: the write wins (counter cleared).
  - A `tick` and a blink wrap in the same clock toggle `phase` once.

## Configuration
- `LED_BLINK_EN` defined: blink counter, `phase` and the `BLINK` register exist as above.
- `LED_BLINK_EN` undefined:
  - `BLINK` reads 0 and writes are ignored;
  - mode 3 behaves as mode 1 (on);
  - no blink logic is generated.

## Structure
- `led_pkg`:
  - `led_mode_e` enum (`LED_OFF`, `LED_ON`, `LED_PWM`, `LED_BLINK`);
  - register offset constants (`LED_CTRL`, `LED_PRESCALE`, `LED_BLINK_R`, `LED_CH_BASE`);
  - the `led_ch_t` packed struct.
- `led_pwm_channel` sub-module, one instance per output:
  - inputs: `clk`, `rst_n`, `en`, `mode`, `duty`, `pwm_cnt`, `phase`;
  - output: registered `led`.
- The top holds the Wishbone logic, registers, prescaler and shared counters.

## Test plan
- Reset: hold `rst_n`=0 for 3 clocks, then release. Every register reads 0, `led`=0 and `ack` has never asserted.
- Read/write and `sel`: write `CH[2]`=0x0001_0080 with `sel`=4'b0101. Reads back 0x0001_0080; `ack` arrives 1 clock after `stb`. A read of offset 0x800 returns 0.
- PWM duty: `EN`=1, `PRESCALE`=0, `CH[0]` mode 2 with `DUTY`=64 (`PWM_W`=8). Over 256 clocks, `led[0]` is high for exactly 64 clocks, repeating every 256 clocks. `DUTY`=0 gives always low.
- Blink, with `LED_BLINK_EN` defined: `PRESCALE`=9, `BLINK`=4, `CH[1]` mode 3. `led[1]` toggles every 50 clocks. Without the macro, `led[1]` stays 1.
- Global disable: with all channels on, write `EN`=0. All `led` are 0 one clock after the write `ack`. Re-enabling restarts PWM from `pwm_cnt`=0.
- Mid-operation reset: assert `rst_n` during an active read with PWM running. No `ack` follows, `led`=0 next clock, and the registers read 0 after release.
